// File: rtl/servo_pwm_pkg.sv
// servo_pwm_pkg: shared constants, selector encodings and FSM states for the servo PWM decoder.
package servo_pwm_pkg;

   localparam int unsigned DEF_PULSE_0_CYC    = 25000;
   localparam int unsigned DEF_PULSE_90_CYC   = 75000;
   localparam int unsigned DEF_PULSE_180_CYC  = 125000;
   localparam int unsigned DEF_PULSE_TOL_CYC  = 500;
   localparam int unsigned DEF_PERIOD_CYC     = 1000000;
   localparam int unsigned DEF_PERIOD_TOL_CYC = 5000;
   localparam int unsigned DEF_TIMEOUT_CYC    = 1040000;
   localparam int unsigned DEF_FILTER_LEN     = 4;

   localparam int unsigned WIDTH_W  = 17;
   localparam int unsigned PERIOD_W = 20;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_0    = 2'd1,
      SEL_90   = 2'd2,
      SEL_180  = 2'd3
   } sel_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_e;

   // Inclusive |val - nom| <= tol without signed arithmetic.
   function automatic logic in_window(input logic [20:0] val, input logic [20:0] nom,
                                      input logic [20:0] tol);
      return (val + tol >= nom) && (val <= nom + tol);
   endfunction

endpackage

// File: rtl/servo_pwm_decoder_edge_sync.sv
// pwm_edge_sync: 2-FF synchronizer, optional glitch filter (SERVO_GLITCH_FILTER_EN), registered rise/fall pulses.
module pwm_edge_sync
   import servo_pwm_pkg::*;
`ifdef SERVO_GLITCH_FILTER_EN
#(
   parameter int unsigned FILTER_LEN = DEF_FILTER_LEN
)
`endif
(
   input  logic Clk_i,
   input  logic Reset_i,
   input  logic Pwm_i,
   output logic Rise_o,
   output logic Fall_o
);

   logic sync1_q, sync2_q, dly_q, rise_q, fall_q;
   logic lvl;

`ifdef SERVO_GLITCH_FILTER_EN
   localparam int unsigned CW = $clog2(FILTER_LEN + 1);
   logic [CW-1:0] cnt_q;
   logic          filt_q;

   // Level follows the synchronizer only after FILTER_LEN stable cycles.
   always_ff @(posedge Clk_i or negedge Reset_i) begin
      if (!Reset_i) begin
         cnt_q  <= '0;
         filt_q <= 1'b0;
      end else if (sync2_q == filt_q) begin
         cnt_q <= '0;
      end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
         filt_q <= sync2_q;
         cnt_q  <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign lvl = filt_q;
`else
   assign lvl = sync2_q;
`endif

   always_ff @(posedge Clk_i or negedge Reset_i) begin
      if (!Reset_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         dly_q   <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= Pwm_i;
         sync2_q <= sync1_q;
         dly_q   <= lvl;
         rise_q  <= lvl & ~dly_q;
         fall_q  <= ~lvl & dly_q;
      end
   end

   assign Rise_o = rise_q;
   assign Fall_o = fall_q;

endmodule

// File: rtl/servo_pwm_decoder.sv
// servo_pwm_decoder: measures servo PWM high time and period, classifies 0/90/180 deg, flags errors and loss of signal.
// Optional glitch filter in the input path is enabled by defining SERVO_GLITCH_FILTER_EN.
module servo_pwm_decoder
   import servo_pwm_pkg::*;
#(
   parameter int unsigned PULSE_0_CYC    = DEF_PULSE_0_CYC,
   parameter int unsigned PULSE_90_CYC   = DEF_PULSE_90_CYC,
   parameter int unsigned PULSE_180_CYC  = DEF_PULSE_180_CYC,
   parameter int unsigned PULSE_TOL_CYC  = DEF_PULSE_TOL_CYC,
   parameter int unsigned PERIOD_CYC     = DEF_PERIOD_CYC,
   parameter int unsigned PERIOD_TOL_CYC = DEF_PERIOD_TOL_CYC,
   parameter int unsigned TIMEOUT_CYC    = DEF_TIMEOUT_CYC
`ifdef SERVO_GLITCH_FILTER_EN
   ,parameter int unsigned FILTER_LEN    = DEF_FILTER_LEN
`endif
) (
   input  logic                Clk_i,
   input  logic                Reset_i,
   input  logic                Pwm_i,
   output logic [WIDTH_W-1:0]  Pulse_width_o,
   output logic [PERIOD_W-1:0] Period_o,
   output logic [1:0]          Sel_o,
   output logic                Valid_o,
   output logic                Pulse_err_o,
   output logic                Period_err_o,
   output logic                Timeout_o
);

   logic rise, fall;

`ifdef SERVO_GLITCH_FILTER_EN
   pwm_edge_sync #(.FILTER_LEN(FILTER_LEN)) u_sync (
      .Clk_i   (Clk_i),
      .Reset_i (Reset_i),
      .Pwm_i   (Pwm_i),
      .Rise_o  (rise),
      .Fall_o  (fall)
   );
`else
   pwm_edge_sync u_sync (
      .Clk_i   (Clk_i),
      .Reset_i (Reset_i),
      .Pwm_i   (Pwm_i),
      .Rise_o  (rise),
      .Fall_o  (fall)
   );
`endif

   state_e              state_q;
   logic [WIDTH_W-1:0]  high_cnt_q, width_q;
   logic [PERIOD_W-1:0] period_cnt_q, period_q;
   sel_e                sel_q, sel_d;
   logic                valid_q, pulse_err_q, period_err_q, timeout_q;
   logic                pulse_err_d, period_err_d;
   logic [20:0]         width_x, period_x;

   assign width_x  = {4'd0, high_cnt_q};
   assign period_x = {1'b0, period_cnt_q};

   always_comb begin
      sel_d        = in_window(width_x, 21'(PULSE_180_CYC), 21'(PULSE_TOL_CYC)) ? SEL_180 :
                     in_window(width_x, 21'(PULSE_90_CYC),  21'(PULSE_TOL_CYC)) ? SEL_90  :
                     in_window(width_x, 21'(PULSE_0_CYC),   21'(PULSE_TOL_CYC)) ? SEL_0   : SEL_NONE;
      pulse_err_d  = (sel_d == SEL_NONE);
      period_err_d = !in_window(period_x, 21'(PERIOD_CYC), 21'(PERIOD_TOL_CYC));
   end

   // A rise outside IDLE closes the previous period; a rise always restarts the counters.
   always_ff @(posedge Clk_i or negedge Reset_i) begin
      if (!Reset_i) begin
         state_q      <= IDLE;
         high_cnt_q   <= '0;
         period_cnt_q <= '0;
         width_q      <= '0;
         period_q     <= '0;
         sel_q        <= SEL_NONE;
         valid_q      <= 1'b0;
         pulse_err_q  <= 1'b0;
         period_err_q <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         valid_q <= 1'b0;
         if (rise && state_q != IDLE) begin
            width_q      <= high_cnt_q;
            period_q     <= period_cnt_q;
            sel_q        <= sel_d;
            pulse_err_q  <= pulse_err_d;
            period_err_q <= period_err_d;
            valid_q      <= 1'b1;
            timeout_q    <= 1'b0;
         end
         if (rise) begin
            state_q      <= HIGH;
            high_cnt_q   <= WIDTH_W'(1);
            period_cnt_q <= PERIOD_W'(1);
         end else if (state_q != IDLE) begin
            if (period_cnt_q == PERIOD_W'(TIMEOUT_CYC)) begin
               state_q   <= IDLE;
               timeout_q <= 1'b1;
            end else begin
               period_cnt_q <= period_cnt_q + PERIOD_W'(1);
               if (state_q == HIGH) begin
                  if (fall) state_q <= LOW;
                  else if (high_cnt_q != '1) high_cnt_q <= high_cnt_q + WIDTH_W'(1);
               end
            end
         end
      end
   end

   assign Pulse_width_o = width_q;
   assign Period_o      = period_q;
   assign Sel_o         = sel_q;
   assign Valid_o       = valid_q;
   assign Pulse_err_o   = pulse_err_q;
   assign Period_err_o  = period_err_q;
   assign Timeout_o     = timeout_q;

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// tb_servo_pwm_decoder: scoreboard bench for servo_pwm_decoder with scaled-down timing parameters.
module tb_servo_pwm_decoder;

   localparam int P0 = 50, P90 = 150, P180 = 250, PT = 10;
   localparam int PER = 2000, PERT = 10, TO = 2080;
`ifdef SERVO_GLITCH_FILTER_EN
   localparam int FLT = 4;
`else
   localparam int FLT = 0;
`endif

   typedef struct {
      int w;
      int p;
      int sel;
      int perr;
      int prerr;
   } exp_t;

   logic        clk = 1'b0, rst_n = 1'b0, pwm = 1'b0;
   logic [16:0] width;
   logic [19:0] period;
   logic [1:0]  sel;
   logic        valid, perr, prerr, tmo;

   exp_t sb[$];
   exp_t pend;
   bit   pend_v = 0;
   int   checks = 0, passes = 0;

   always #10 clk = ~clk;

   servo_pwm_decoder #(
      .PULSE_0_CYC    (P0),
      .PULSE_90_CYC   (P90),
      .PULSE_180_CYC  (P180),
      .PULSE_TOL_CYC  (PT),
      .PERIOD_CYC     (PER),
      .PERIOD_TOL_CYC (PERT),
      .TIMEOUT_CYC    (TO)
   ) dut (
      .Clk_i         (clk),
      .Reset_i       (rst_n),
      .Pwm_i         (pwm),
      .Pulse_width_o (width),
      .Period_o      (period),
      .Sel_o         (sel),
      .Valid_o       (valid),
      .Pulse_err_o   (perr),
      .Period_err_o  (prerr),
      .Timeout_o     (tmo)
   );

   function automatic int absd(input int a, input int b);
      return (a > b) ? a - b : b - a;
   endfunction

   function automatic int cls(input int w);
      return (absd(w, P180) <= PT) ? 3 : (absd(w, P90) <= PT) ? 2 : (absd(w, P0) <= PT) ? 1 : 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) passes++;
      else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
   endtask

   task automatic set_pend(input int w, input int p);
      pend.w     = w;
      pend.p     = p;
      pend.sel   = cls(w);
      pend.perr  = (cls(w) == 0) ? 1 : 0;
      pend.prerr = (absd(p, PER) > PERT) ? 1 : 0;
      pend_v     = 1;
   endtask

   // The segment in flight is published by the next rising edge.
   task automatic rise_h(input int h);
      if (pend_v) sb.push_back(pend);
      pwm = 1'b1;
      repeat (h) @(negedge clk);
      pwm = 1'b0;
   endtask

   task automatic seg(input int h, input int l);
      rise_h(h);
      set_pend(h, h + l);
      repeat (l) @(negedge clk);
   endtask

   task automatic glitch(input int a, input int g, input int b, input int l);
`ifdef SERVO_GLITCH_FILTER_EN
      if (pend_v) sb.push_back(pend);
      pwm = 1'b1;
      repeat (a) @(negedge clk);
      pwm = 1'b0;
      repeat (g) @(negedge clk);
      pwm = 1'b1;
      repeat (b) @(negedge clk);
      pwm = 1'b0;
      set_pend(a + g + b, a + g + b + l);
      repeat (l) @(negedge clk);
`else
      rise_h(a);
      set_pend(a, a + g);
      repeat (g) @(negedge clk);
      seg(b, l);
`endif
   endtask

   always @(negedge clk) begin
      if (valid) begin : mon
         exp_t e;
         if (sb.size() == 0) chk("sb_depth_on_valid", 32'(sb.size()), 1);
         else begin
            e = sb.pop_front();
            chk("width", width, e.w);
            chk("period", period, e.p);
            chk("sel", sel, e.sel);
            chk("pulse_err", perr, e.perr);
            chk("period_err", prerr, e.prerr);
         end
      end
   end

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_width", width, 0);
      chk("rst_period", period, 0);
      chk("rst_sel", sel, 0);
      chk("rst_valid", valid, 0);
      chk("rst_perr", perr, 0);
      chk("rst_prerr", prerr, 0);
      chk("rst_tmo", tmo, 0);
      rst_n = 1'b1;
      repeat (5) @(negedge clk);

      repeat (3) seg(250, 1750);
      seg(50, 1950);
      seg(150, 1850);
      seg(160, 1840);
      seg(161, 1839);
      seg(150, 1861);
      seg(150, 1840);
      seg(150, 1860);

      rise_h(150);
      pend_v = 0;
      repeat (TO + 3 + FLT - 150) @(negedge clk);
      chk("tmo_before", tmo, 0);
      @(negedge clk);
      chk("tmo_set", tmo, 1);
      chk("tmo_hold_period", period, 2010);
      seg(150, 1850);
      chk("tmo_after_arm", tmo, 1);
      seg(150, 1850);
      chk("tmo_cleared", tmo, 0);

      sb.push_back(pend);
      pend_v = 0;
      pwm = 1'b1;
      repeat (100) @(negedge clk);
      chk("pre_rst_period", period, 2000);
      chk("pre_rst_sel", sel, 2);
      #5 rst_n = 1'b0;
      #1;
      chk("async_rst_width", width, 0);
      chk("async_rst_period", period, 0);
      chk("async_rst_sel", sel, 0);
      repeat (5) @(negedge clk);
      pwm = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      seg(150, 1850);
      chk("no_valid_after_rst", period, 0);
      seg(150, 1850);

      glitch(100, 1, 149, 1750);
      glitch(100, 3, 147, 1750);
      rise_h(10);
      repeat (20) @(negedge clk);
      chk("sb_empty", 32'(sb.size()), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
